// File: rtl/sum_sequencer.sv
// -----------------------------------------------------------------------------
// sum_sequencer
//
// Run controller for the switch-driven summation datapath. The raw start
// switch is synchronized and debounced. Each accepted rising edge launches
// one run:
//   1. capture the operand switches,
//   2. pulse the sum unit's reset,
//   3. hold start until the sum unit reports done, or until the timeout expires,
//   4. latch the result,
//   5. raise an LCD refresh request and hold it until it is acknowledged.
//
// Ports
//   clk_i        system clock
//   rst_i        synchronous active-high reset
//   start_sw_i   raw start switch (asynchronous)
//   data_sw_i    raw data operand switches
//   n_sw_i       raw count operand switches
//   sum_rst_no   active-low reset to the sum unit
//   sum_start_o  start level to the sum unit
//   sum_data_o   latched data operand
//   sum_n_o      latched count operand
//   sum_done_i   done flag from the sum unit
//   sum_i        sum unit result
//   result_o     latched result for the hex-to-decimal converter
//   lcd_req_o    LCD refresh request
//   lcd_ack_i    LCD refresh accepted
//   busy_o       run in progress
//   done_o       last run completed normally
//   timeout_o    last run aborted on timeout
// -----------------------------------------------------------------------------
module sum_sequencer #(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int TIMEOUT_CYC  = 4096
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_sw_i,
    input  logic [7:0]  data_sw_i,
    input  logic [7:0]  n_sw_i,
    output logic        sum_rst_no,
    output logic        sum_start_o,
    output logic [7:0]  sum_data_o,
    output logic [7:0]  sum_n_o,
    input  logic        sum_done_i,
    input  logic [15:0] sum_i,
    output logic [15:0] result_o,
    output logic        lcd_req_o,
    input  logic        lcd_ack_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        timeout_o
);

    localparam int DBW = $clog2(DEBOUNCE_CYC + 1);
    localparam int TW  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYC - 1);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LAUNCH,
        S_WAIT_DONE,
        S_LCD_REQ,
        S_DONE,
        S_ERROR
    } state_t;

    // -------------------------------------------------------------------------
    // Start switch: 2-flop synchronizer. It is deliberately left out of reset
    // so that it tracks the real switch level while rst_i is held.
    // -------------------------------------------------------------------------
    logic sync1_q, sync2_q;

    always_ff @(posedge clk_i) begin
        sync1_q <= start_sw_i;
        sync2_q <= sync1_q;
    end

    // -------------------------------------------------------------------------
    // Debounce. The accepted level db_q follows sync2_q only after
    // DEBOUNCE_CYC consecutive cycles of disagreement; any agreement restarts
    // the count.
    //
    // armed_q blocks start events until the debounced switch has been seen
    // low after reset. A switch held high through reset therefore cannot
    // launch a run.
    // -------------------------------------------------------------------------
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic           db_q, db_d;
    logic           db_prev_q;
    logic           armed_q, armed_d;
    logic           start_evt;

    always_comb begin
        db_cnt_d = '0;
        db_d     = db_q;
        armed_d  = armed_q;
        if (sync2_q != db_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_d     = sync2_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
        if (!db_q && !sync2_q) begin
            armed_d = 1'b1;
        end
    end

    assign start_evt = db_q & ~db_prev_q & armed_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            db_cnt_q  <= '0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            db_cnt_q  <= db_cnt_d;
            db_q      <= db_d;
            db_prev_q <= db_q;
            armed_q   <= armed_d;
        end
    end

    // -------------------------------------------------------------------------
    // Run FSM
    // -------------------------------------------------------------------------
    state_t         state_q, state_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic [15:0]    result_q, result_d;
    logic [7:0]     data_q, data_d;
    logic [7:0]     n_q, n_d;

    always_comb begin
        state_d  = state_q;
        tmo_d    = tmo_q;
        result_d = result_q;
        data_d   = data_q;
        n_d      = n_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_evt) begin
                    state_d = S_CLEAR;
                    data_d  = data_sw_i;
                    n_d     = n_sw_i;
                end
            end
            S_CLEAR: state_d = S_LAUNCH;
            S_LAUNCH: begin
                tmo_d   = '0;
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                // When done and the timeout limit coincide, done wins.
                if (sum_done_i) begin
                    result_d = sum_i;
                    state_d  = S_LCD_REQ;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_LCD_REQ: begin
                if (lcd_ack_i) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state, so each output changes on
    // the same edge as the state it belongs to.
    logic sum_rst_n_q, sum_start_q, lcd_req_q, busy_q, done_q, timeout_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            tmo_q       <= '0;
            result_q    <= '0;
            data_q      <= '0;
            n_q         <= '0;
            sum_rst_n_q <= 1'b0;
            sum_start_q <= 1'b0;
            lcd_req_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            result_q    <= result_d;
            data_q      <= data_d;
            n_q         <= n_d;
            sum_rst_n_q <= (state_d != S_CLEAR);
            sum_start_q <= (state_d == S_LAUNCH) || (state_d == S_WAIT_DONE);
            lcd_req_q   <= (state_d == S_LCD_REQ);
            busy_q      <= (state_d == S_CLEAR) || (state_d == S_LAUNCH) ||
                           (state_d == S_WAIT_DONE) || (state_d == S_LCD_REQ);
            done_q      <= (state_d == S_DONE);
            timeout_q   <= (state_d == S_ERROR);
        end
    end

    assign sum_rst_no  = sum_rst_n_q;
    assign sum_start_o = sum_start_q;
    assign sum_data_o  = data_q;
    assign sum_n_o     = n_q;
    assign result_o    = result_q;
    assign lcd_req_o   = lcd_req_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_sum_sequencer.sv
// Testbench for sum_sequencer.
// Operates with DEBOUNCE_CYC=4 and TIMEOUT_CYC=16. A scoreboard queue
// receives one entry per launched run. A monitor process pops that entry
// when the run finishes, either by raising an LCD request or by timing out.
// The same process also models the sum unit and the LCD handshake.
module tb_sum_sequencer;
    localparam int DEB = 4;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_i, start_sw_i, sum_done_i, lcd_ack_i;
    logic [7:0]  data_sw_i, n_sw_i;
    logic [15:0] sum_i;
    logic        sum_rst_no, sum_start_o, lcd_req_o, busy_o, done_o, timeout_o;
    logic [7:0]  sum_data_o, sum_n_o;
    logic [15:0] result_o;

    always #5 clk = ~clk;

    sum_sequencer #(.DEBOUNCE_CYC(DEB), .TIMEOUT_CYC(TMO)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_sw_i(start_sw_i),
        .data_sw_i(data_sw_i), .n_sw_i(n_sw_i),
        .sum_rst_no(sum_rst_no), .sum_start_o(sum_start_o),
        .sum_data_o(sum_data_o), .sum_n_o(sum_n_o),
        .sum_done_i(sum_done_i), .sum_i(sum_i), .result_o(result_o),
        .lcd_req_o(lcd_req_o), .lcd_ack_i(lcd_ack_i),
        .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o)
    );

    typedef struct {
        bit          is_tmo;
        logic [15:0] res;
        logic [7:0]  d;
        logic [7:0]  n;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    logic [15:0] last_res = 16'h0;

    // Behaviour knobs for the sum unit and LCD models.
    int done_delay = 6;
    int ack_delay  = 2;

    // Event counters kept by the monitor.
    int completions = 0, lcd_rises = 0, clear_falls = 0, last_start_len = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor and responders. Samples 1 time unit after each rising edge.
    // ------------------------------------------------------------------
    initial begin
        logic p_req, p_ack, p_tmo, p_done, p_rstn, p_start;
        int   sum_cnt, lcd_cnt, req_len, start_len;
        exp_t e;
        p_req = 0; p_ack = 0; p_tmo = 0; p_done = 0; p_rstn = 0; p_start = 0;
        sum_cnt = 0; lcd_cnt = 0; req_len = 0; start_len = 0;
        sum_done_i = 0; sum_i = 0; lcd_ack_i = 0;
        forever begin
            @(posedge clk); #1;
            if (!rst_i) begin
                if (lcd_req_o && !p_req) begin
                    lcd_rises++;
                    chk("lcd_req_expected", exp_q.size(), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("run_kind_normal", timeout_o, 32'(e.is_tmo));
                        chk("result", result_o, e.res);
                        chk("op_data", sum_data_o, e.d);
                        chk("op_n", sum_n_o, e.n);
                        last_res = e.res;
                    end
                end
                if (timeout_o && !p_tmo) begin
                    completions++;
                    chk("timeout_expected", exp_q.size(), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("run_kind_timeout", 32'(e.is_tmo), 1);
                        chk("result_hold", result_o, last_res);
                        chk("op_data_tmo", sum_data_o, e.d);
                    end
                end
                if (done_o && !p_done) completions++;
                if (p_req && p_ack) begin
                    chk("req_drop_after_ack", lcd_req_o, 0);
                    chk("done_after_ack", done_o, 1);
                    chk("busy_after_ack", busy_o, 0);
                    chk("req_len", req_len, ack_delay);
                end else if (p_req) begin
                    chk("req_held", lcd_req_o, 1);
                end
                if (!sum_rst_no) begin
                    if (p_rstn) clear_falls++;
                    chk("clear_one_cycle", p_rstn, 1);
                end
            end
            if (lcd_req_o) req_len++; else req_len = 0;
            if (sum_start_o) start_len++;
            else if (p_start) begin last_start_len = start_len; start_len = 0; end

            // Sum unit model: result = data * n after done_delay start cycles.
            if (!sum_rst_no) begin
                sum_cnt = 0; sum_done_i = 0;
            end else if (sum_start_o) begin
                sum_cnt++;
                if (sum_cnt >= done_delay) begin
                    sum_done_i = 1;
                    sum_i = 16'(sum_data_o) * 16'(sum_n_o);
                end else begin
                    sum_i = 16'($urandom);
                end
            end
            // LCD model: acknowledge on the ack_delay-th request cycle.
            if (lcd_req_o && !lcd_ack_i) begin
                lcd_cnt++;
                lcd_ack_i = (lcd_cnt == ack_delay);
            end else begin
                lcd_cnt = 0; lcd_ack_i = 0;
            end
            p_req = lcd_req_o; p_ack = lcd_ack_i; p_tmo = timeout_o;
            p_done = done_o; p_rstn = sum_rst_no; p_start = sum_start_o;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    // Press the start switch long enough to be accepted, then release it.
    // After capture, the operand switches are scrambled.
    task automatic press(input logic [7:0] d, input logic [7:0] n,
                         input bit tmo, input bit hold);
        exp_t e;
        data_sw_i = d; n_sw_i = n; start_sw_i = 1;
        e.is_tmo = tmo; e.res = 16'(d) * 16'(n); e.d = d; e.n = n;
        exp_q.push_back(e);
        repeat (6) @(negedge clk);
        if (!hold) start_sw_i = 0;
        repeat (2) @(negedge clk);
        data_sw_i = 8'($urandom); n_sw_i = 8'($urandom);
        repeat (6) @(negedge clk);
    endtask

    task automatic wait_runs(input int target);
        int k = 0;
        while (completions < target && k < 300) begin
            @(negedge clk); k++;
        end
        chk("run_completion", completions, target);
    endtask

    task automatic chk_reset_vals();
        chk("rst_sum_rst_no", sum_rst_no, 0);
        chk("rst_sum_start", sum_start_o, 0);
        chk("rst_lcd_req", lcd_req_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_timeout", timeout_o, 0);
        chk("rst_result", result_o, 0);
        chk("rst_data", sum_data_o, 0);
        chk("rst_n", sum_n_o, 0);
    endtask

    initial begin
        int tgt, cf, lr, k;
        rst_i = 1; start_sw_i = 0; data_sw_i = 0; n_sw_i = 0;
        repeat (4) @(negedge clk);
        chk_reset_vals();
        rst_i = 0;
        repeat (10) @(negedge clk);
        chk("idle_sum_rst_n", sum_rst_no, 1);
        chk("idle_busy", busy_o, 0);

        // Normal run, with the operand switches changing mid-run.
        done_delay = 6; ack_delay = 2;
        tgt = completions + 1;
        press(8'd3, 8'd5, 0, 0);
        wait_runs(tgt);
        chk("normal_result", result_o, 16'h000F);
        chk("normal_done", done_o, 1);
        chk("normal_busy", busy_o, 0);
        chk("normal_timeout", timeout_o, 0);
        repeat (5) @(negedge clk);
        chk("hold_data", sum_data_o, 8'd3);
        chk("hold_n", sum_n_o, 8'd5);

        // Bounce: exactly one CLEAR, seven cycles after the final rise.
        cf = clear_falls; tgt = completions + 1;
        data_sw_i = 8'd7; n_sw_i = 8'd4;
        exp_q.push_back('{1'b0, 16'd28, 8'd7, 8'd4});
        for (int i = 0; i < 4; i++) begin
            start_sw_i = ~i[0];
            repeat (2) @(negedge clk);
        end
        start_sw_i = 1; k = 0;
        while (!busy_o && k < 30) begin @(negedge clk); k++; end
        chk("bounce_latency", k, 7);
        repeat (8) @(negedge clk);
        start_sw_i = 0;
        wait_runs(tgt);
        repeat (10) @(negedge clk);
        chk("bounce_single_clear", clear_falls, cf + 1);

        // Timeout: the sum unit never finishes.
        done_delay = 1000; lr = lcd_rises; tgt = completions + 1;
        press(8'h11, 8'h22, 1, 0);
        wait_runs(tgt);
        chk("tmo_flag", timeout_o, 1);
        chk("tmo_done", done_o, 0);
        chk("tmo_result_kept", result_o, 16'h001C);
        chk("tmo_start_cycles", last_start_len, 17);
        chk("tmo_no_lcd", lcd_rises, lr);
        done_delay = 4; tgt = completions + 1;
        press(8'd2, 8'd9, 0, 0);
        wait_runs(tgt);
        chk("recover_timeout_clr", timeout_o, 0);
        chk("recover_done", done_o, 1);
        chk("recover_result", result_o, 16'h0012);

        // Done on the last allowed cycle beats the timeout, one later loses.
        done_delay = 17; tgt = completions + 1;
        press(8'd10, 8'd10, 0, 0);
        wait_runs(tgt);
        chk("edge_done_wins", done_o, 1);
        done_delay = 18; tgt = completions + 1;
        press(8'd1, 8'd1, 1, 0);
        wait_runs(tgt);
        chk("edge_timeout", timeout_o, 1);
        chk("edge_result_kept", result_o, 16'd100);

        // Second start event during WAIT_DONE is dropped.
        done_delay = 15; cf = clear_falls; lr = lcd_rises; tgt = completions + 1;
        press(8'd6, 8'd7, 0, 0);
        start_sw_i = 1;
        repeat (8) @(negedge clk);
        start_sw_i = 0;
        wait_runs(tgt);
        repeat (20) @(negedge clk);
        chk("busy_one_clear", clear_falls, cf + 1);
        chk("busy_one_lcd", lcd_rises, lr + 1);
        chk("busy_one_run", completions, tgt);
        chk("busy_result", result_o, 16'd42);

        // Randomized runs against the spec-level model.
        for (int r = 0; r < 10; r++) begin
            logic [7:0] d, n;
            bit t;
            d = 8'($urandom); n = 8'($urandom);
            done_delay = $urandom_range(1, 22);
            ack_delay  = $urandom_range(1, 4);
            t = (done_delay > 17);
            tgt = completions + 1;
            press(d, n, t, 0);
            wait_runs(tgt);
            chk("rand_done", done_o, 32'(!t));
            chk("rand_timeout", timeout_o, 32'(t));
            repeat (4) @(negedge clk);
        end

        // Reset during LCD_REQ with the switch held high.
        ack_delay = 1000; done_delay = 3;
        press(8'd5, 8'd5, 0, 1);
        chk("reached_lcd_req", lcd_req_o, 1);
        rst_i = 1;
        repeat (2) @(negedge clk);
        chk_reset_vals();
        last_res = 16'h0;
        rst_i = 0; ack_delay = 2;
        cf = clear_falls; tgt = completions;
        repeat (40) @(negedge clk);
        chk("post_rst_no_run", clear_falls, cf);
        chk("post_rst_busy", busy_o, 0);
        chk("post_rst_sum_rst_n", sum_rst_no, 1);
        chk("post_rst_result", result_o, 0);
        start_sw_i = 0;
        repeat (12) @(negedge clk);
        done_delay = 5; tgt = completions + 1;
        press(8'd8, 8'd8, 0, 0);
        wait_runs(tgt);
        chk("post_rst_run", result_o, 16'h0040);
        chk("queue_drained", exp_q.size(), 0);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sum_sequencer.md
# sum_sequencer

Run controller for the switch-driven summation datapath. It debounces the raw start switch and captures the operand switches at launch. It clears and starts the sum unit, waits for its done flag with a timeout, latches the 16-bit result for the decimal converter, then hands an LCD refresh request to the display block. It sits between the board switches and the sum unit / hex-to-decimal / LCD chain in the top level.

## Interface
Parameters:
- DEBOUNCE_CYC, default 1_000_000: cycles the synchronized start switch must hold a new level before it is accepted (20 ms at 50 MHz).
- TIMEOUT_CYC, default 4096: maximum cycles spent in WAIT_DONE before declaring a fault.

Ports:
- clk_i  in  1  system clock (CLOCK_50); single clock domain.
- rst_i  in  1  synchronous, active-high reset.
- start_sw_i  in  1  raw start switch; asynchronous to clk_i.
- data_sw_i  in  8  raw data operand switches.
- n_sw_i  in  8  raw count operand switches.
- sum_rst_no  out  1  active-low reset to the sum unit.
- sum_start_o  out  1  start level to the sum unit.
- sum_data_o  out  8  latched data operand.
- sum_n_o  out  8  latched count operand.
- sum_done_i  in  1  done flag from the sum unit.
- sum_i  in  16  sum-unit result.
- result_o  out  16  latched result to the hex-to-decimal converter.
- lcd_req_o  out  1  LCD refresh request.
- lcd_ack_i  in  1  LCD refresh accepted.
- busy_o  out  1  run in progress.
- done_o  out  1  last run completed normally.
- timeout_o  out  1  last run aborted on timeout.

## Operation
- Start path: 2-flop synchronizer on start_sw_i feeds a debounce counter.
  - The debounced level db changes only after the synchronizer output differs from db for DEBOUNCE_CYC consecutive cycles.
  - The counter resets on any bounce.
  - A start event is a 0→1 transition of db.
- Start events are honored only in IDLE, DONE and ERROR. Start events in any other state are dropped, not queued.
- States and transitions:
  - IDLE: start event → CLEAR. Operands are captured from data_sw_i and n_sw_i in the same cycle.
  - CLEAR: sum_rst_no=0 for exactly 1 cycle, then LAUNCH.
  - LAUNCH: sum_start_o=1; the timeout counter is zeroed; then WAIT_DONE.
  - WAIT_DONE: sum_start_o stays 1; the counter increments each cycle.
    - sum_done_i=1 → result_o<=sum_i, then LCD_REQ.
    - Otherwise, counter==TIMEOUT_CYC-1 → ERROR.
    - If done and the timeout limit occur in the same cycle, done wins.
  - LCD_REQ: lcd_req_o=1, held until lcd_ack_i=1 is sampled. Then the block deasserts lcd_req_o next cycle and enters DONE. There is no timeout on the ack.
  - DONE: done_o=1. A start event → CLEAR: re-capture operands and clear done_o.
  - ERROR: timeout_o=1; result_o keeps its previous value. A start event → CLEAR: clear timeout_o.
- busy_o=1 in CLEAR, LAUNCH, WAIT_DONE and LCD_REQ.
- Operands are stable from capture until the next capture; switch changes mid-run have no effect.
- Width rules:
  - result_o is a straight 16-bit copy of sum_i; no saturation.
  - The timeout counter must be wide enough for TIMEOUT_CYC without wrapping.
- Reset:
  - rst_i in any state → IDLE next edge, with sum_rst_no=0 while rst_i is high.
  - Reset clears the debounce counter and forces db to 0, so a switch held high through reset does not generate a start event.

## Timing
- Reset values:
  - sum_rst_no=0 while rst_i is high, 1 afterward in IDLE.
  - sum_start_o=0, lcd_req_o=0, busy_o=0, done_o=0, timeout_o=0.
  - result_o=16'h0000, sum_data_o=8'h00, sum_n_o=8'h00.
- Raw edge to db rise: 2 + DEBOUNCE_CYC cycles.
- db rise to CLEAR: 1 cycle.
- CLEAR to sum_start_o high: 1 cycle.
- sum_done_i high to result_o valid and lcd_req_o high: 1 cycle.
- lcd_ack_i high to done_o high and lcd_req_o low: 1 cycle.
- sum_start_o drops the same cycle the state leaves WAIT_DONE.
- All outputs are registered.

## Test plan
Run with DEBOUNCE_CYC=4 and TIMEOUT_CYC=16.
- Normal run: data=3, n=5; sum unit model asserts done after 6 cycles with sum=15; ack after 2 cycles.
  - Required: result_o=16'h000F, lcd_req_o held exactly until ack, done_o=1, busy_o=0.
- Bounce: start_sw toggles 1,0,1,0 every 2 cycles, then holds 1.
  - Required: exactly one CLEAR, occurring 2+4+1 cycles after the final rise.
- Timeout: the sum model never asserts done.
  - Required: ERROR after 16 WAIT_DONE cycles; timeout_o=1; result_o unchanged; lcd_req_o never asserted.
  - Then a new start event → timeout_o=0 and a normal run completes.
- Start during busy: a second start event arrives in WAIT_DONE.
  - Required: ignored; exactly one result and one lcd_req.
- Operand change mid-run: the switches change to data=9, n=2 during WAIT_DONE.
  - Required: sum_data_o=3 and sum_n_o=5 stay unchanged until the next capture.
- Reset mid-run: rst_i pulsed during LCD_REQ with start_sw held high.
  - Required: IDLE with all reset values; no new run until the switch goes low and then high again.
